// File: rtl/memory_access_pkg.sv
// Shared load/store width codes and controller state encoding for the data memory path.
package memory_access_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_DONE   = 2'b10
    } dmem_state_t;

    // Unsigned load widths have no store counterpart.
    function automatic logic store_width_ok(input logic [2:0] f3);
        logic ok_v;
        case (f3)
            F3_B, F3_H, F3_W: ok_v = 1'b1;
            default:          ok_v = 1'b0;
        endcase
        return ok_v;
    endfunction

endpackage

// File: rtl/load_store_align.sv
// Combinational byte-lane steering: store lane replication/enables, load extraction/extension,
// and alignment / width-code legality.
module load_store_align
    import memory_access_pkg::*;
(
    input  logic [2:0]  func3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] write_data,
    input  logic [31:0] mm_readdata,
    output logic [3:0]  byteenable,
    output logic [31:0] lane_wdata,
    output logic [31:0] load_data,
    output logic        bad_access
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Pick the addressed byte and half-word out of the fetched word.
    always_comb begin
        byte_s = 8'h00;
        case (addr_lo)
            2'b00:   byte_s = mm_readdata[7:0];
            2'b01:   byte_s = mm_readdata[15:8];
            2'b10:   byte_s = mm_readdata[23:16];
            2'b11:   byte_s = mm_readdata[31:24];
            default: byte_s = 8'h00;
        endcase
        if (addr_lo[1]) begin
            half_s = mm_readdata[31:16];
        end else begin
            half_s = mm_readdata[15:0];
        end
    end

    // Per-width lane enables, replicated store data, extended load data and legality.
    always_comb begin
        byteenable = 4'b0000;
        lane_wdata = 32'h0000_0000;
        load_data  = 32'h0000_0000;
        bad_access = 1'b0;
        case (func3)
            F3_B: begin
                byteenable = 4'b0001 << addr_lo;
                lane_wdata = {4{write_data[7:0]}};
                load_data  = {{24{byte_s[7]}}, byte_s};
            end
            F3_BU: begin
                byteenable = 4'b0001 << addr_lo;
                lane_wdata = {4{write_data[7:0]}};
                load_data  = {24'h00_0000, byte_s};
            end
            F3_H: begin
                byteenable = 4'b0011 << addr_lo;
                lane_wdata = {2{write_data[15:0]}};
                load_data  = {{16{half_s[15]}}, half_s};
                bad_access = addr_lo[0];
            end
            F3_HU: begin
                byteenable = 4'b0011 << addr_lo;
                lane_wdata = {2{write_data[15:0]}};
                load_data  = {16'h0000, half_s};
                bad_access = addr_lo[0];
            end
            F3_W: begin
                byteenable = 4'b1111;
                lane_wdata = write_data;
                load_data  = mm_readdata;
                bad_access = (addr_lo != 2'b00);
            end
            default: begin
                bad_access = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/data_memory_controller.sv
// Pipeline-facing data memory controller: IDLE/ACCESS/DONE handshake onto a multi-cycle
// word-wide memory port. Define DMEM_TIMEOUT_EN to build the ACCESS watchdog.
module data_memory_controller
    import memory_access_pkg::*;
#(
    parameter int WORD_ADDR_BITS = 10,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic                      mem_read,
    input  logic                      mem_write,
    input  logic [2:0]                func3,
    input  logic [31:0]               address,
    input  logic [31:0]               write_data,
    output logic [31:0]               read_data,
    output logic                      busywait,
    output logic                      access_error,
    output logic                      mm_read,
    output logic                      mm_write,
    output logic [WORD_ADDR_BITS-1:0] mm_address,
    output logic [31:0]               mm_writedata,
    output logic [3:0]                mm_byteenable,
    input  logic [31:0]               mm_readdata,
    input  logic                      mm_busywait
);

    dmem_state_t state_r;
    dmem_state_t state_s;

    logic [2:0]  func3_r;
    logic [1:0]  addr_lo_r;
    logic        is_store_r;
    logic        first_r;

    logic        req_s;
    logic        illegal_s;
    logic        mm_ready_s;
    logic        timeout_s;
    logic        busy_s;
    logic [2:0]  al_func3_s;
    logic [1:0]  al_addr_s;
    logic [3:0]  be_s;
    logic [31:0] wdata_s;
    logic [31:0] ldata_s;
    logic        bad_s;
    logic        unused_s;

    assign req_s    = mem_read | mem_write;
    assign unused_s = ^{address[31:WORD_ADDR_BITS+2]};

    // While idle the aligner checks the live request; afterwards it formats the latched one.
    always_comb begin
        if (state_r == ST_IDLE) begin
            al_func3_s = func3;
            al_addr_s  = address[1:0];
        end else begin
            al_func3_s = func3_r;
            al_addr_s  = addr_lo_r;
        end
    end

    load_store_align u_align (
        .func3       (al_func3_s),
        .addr_lo     (al_addr_s),
        .write_data  (write_data),
        .mm_readdata (mm_readdata),
        .byteenable  (be_s),
        .lane_wdata  (wdata_s),
        .load_data   (ldata_s),
        .bad_access  (bad_s)
    );

    assign illegal_s = bad_s | (mem_write & ~store_width_ok(func3));

    // The memory only sees the strobe after the first ACCESS edge, so its busywait is ignored then.
    assign mm_ready_s = ~first_r & ~mm_busywait;

`ifdef DMEM_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] wd_cnt_r;

    assign timeout_s = (state_r == ST_ACCESS) & ~first_r & mm_busywait
                     & (wd_cnt_r == TW'(TIMEOUT_CYCLES - 1));

    // Watchdog: counts stalled ACCESS cycles, cleared whenever a new access starts.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wd_cnt_r <= {TW{1'b0}};
        end else if (state_r != ST_ACCESS) begin
            wd_cnt_r <= {TW{1'b0}};
        end else if (~first_r & mm_busywait) begin
            wd_cnt_r <= wd_cnt_r + {{(TW-1){1'b0}}, 1'b1};
        end
    end
`else
    assign timeout_s = 1'b0;
`endif

    // State register.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode and pipeline stall.
    always_comb begin
        state_s = state_r;
        busy_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                busy_s = req_s;
                if (!req_s) begin
                    state_s = ST_IDLE;
                end else if (illegal_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                busy_s = 1'b1;
                if (mm_ready_s || timeout_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_ACCESS;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Stall must drop with reset even while a request is presented.
    assign busywait = busy_s & ~RESET;

    // Request latch, memory-port outputs, load result and error pulse.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            func3_r       <= 3'b000;
            addr_lo_r     <= 2'b00;
            is_store_r    <= 1'b0;
            first_r       <= 1'b0;
            read_data     <= 32'h0000_0000;
            access_error  <= 1'b0;
            mm_read       <= 1'b0;
            mm_write      <= 1'b0;
            mm_address    <= {WORD_ADDR_BITS{1'b0}};
            mm_writedata  <= 32'h0000_0000;
            mm_byteenable <= 4'b0000;
        end else begin
            access_error <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (req_s) begin
                        func3_r    <= func3;
                        addr_lo_r  <= address[1:0];
                        is_store_r <= mem_write;
                        first_r    <= 1'b1;
                        if (illegal_s) begin
                            access_error <= 1'b1;
                            read_data    <= 32'h0000_0000;
                        end else begin
                            mm_read       <= ~mem_write;
                            mm_write      <= mem_write;
                            mm_address    <= address[WORD_ADDR_BITS+1:2];
                            mm_writedata  <= mem_write ? wdata_s : 32'h0000_0000;
                            mm_byteenable <= mem_write ? be_s : 4'b0000;
                        end
                    end
                end
                ST_ACCESS: begin
                    first_r <= 1'b0;
                    if (timeout_s) begin
                        mm_read       <= 1'b0;
                        mm_write      <= 1'b0;
                        mm_byteenable <= 4'b0000;
                        access_error  <= 1'b1;
                        if (!is_store_r) begin
                            read_data <= 32'h0000_0000;
                        end
                    end else if (mm_ready_s) begin
                        mm_read       <= 1'b0;
                        mm_write      <= 1'b0;
                        mm_byteenable <= 4'b0000;
                        if (!is_store_r) begin
                            read_data <= ldata_s;
                        end
                    end
                end
                default: begin
                    first_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_memory_controller.sv
// Directed, table-driven bench for data_memory_controller with a small wait-state memory model.
module tb_data_memory_controller;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        mem_read, mem_write;
    logic [2:0]  func3;
    logic [31:0] address, write_data;
    logic [31:0] read_data;
    logic        busywait, access_error, mm_read, mm_write;
    logic [9:0]  mm_address;
    logic [31:0] mm_writedata;
    logic [3:0]  mm_byteenable;
    logic [31:0] mm_readdata;
    logic        mm_busywait;

    int errors = 0;
    int checks = 0;
    int wait_cfg = 0;
    int mem_cnt = 0;
    bit mem_seen = 1'b0;

    data_memory_controller dut (
        .CLK(CLK), .RESET(RESET), .mem_read(mem_read), .mem_write(mem_write),
        .func3(func3), .address(address), .write_data(write_data),
        .read_data(read_data), .busywait(busywait), .access_error(access_error),
        .mm_read(mm_read), .mm_write(mm_write), .mm_address(mm_address),
        .mm_writedata(mm_writedata), .mm_byteenable(mm_byteenable),
        .mm_readdata(mm_readdata), .mm_busywait(mm_busywait)
    );

    always #5 CLK = ~CLK;

    // Memory model: after first seeing a strobe it stalls for wait_cfg cycles.
    always @(posedge CLK) begin
        #1;
        if (!(mm_read || mm_write)) begin
            mem_seen    = 1'b0;
            mm_busywait = 1'b0;
        end else if (!mem_seen) begin
            mem_seen    = 1'b1;
            mem_cnt     = wait_cfg;
            mm_busywait = 1'b0;
        end else if (mem_cnt > 0) begin
            mm_busywait = 1'b1;
            mem_cnt     = mem_cnt - 1;
        end else begin
            mm_busywait = 1'b0;
        end
    end

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] mrd;
        int          waitc;
        int          exp_busy;
        logic        exp_srd;
        logic        exp_swr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd;
        logic [9:0]  exp_ma;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vecs[18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int          busy;
        logic        srd, swr, err, done;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [9:0]  ma;
        @(posedge CLK); #1;
        mem_read = v.rd; mem_write = v.wr; func3 = v.f3;
        address = v.addr; write_data = v.wd; mm_readdata = v.mrd; wait_cfg = v.waitc;
        busy = 0; srd = 1'b0; swr = 1'b0; err = 1'b0; done = 1'b0;
        be = 4'b0000; wd = 32'h0; ma = 10'h0;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge CLK);
            if (mm_read || mm_write) begin
                srd = srd | mm_read; swr = swr | mm_write;
                be = mm_byteenable; wd = mm_writedata; ma = mm_address;
            end
            if (busywait) begin
                busy++;
            end else begin
                done = 1'b1;
                err  = access_error;
                chk({tag, "_read_data"}, read_data, v.exp_rd);
            end
        end
        chk({tag, "_completed"}, {31'h0, done}, 32'h1);
        chk({tag, "_busy_cycles"}, busy, v.exp_busy);
        chk({tag, "_mm_read"}, {31'h0, srd}, {31'h0, v.exp_srd});
        chk({tag, "_mm_write"}, {31'h0, swr}, {31'h0, v.exp_swr});
        chk({tag, "_access_error"}, {31'h0, err}, {31'h0, v.exp_err});
        if (v.exp_swr) begin
            chk({tag, "_byteenable"}, {28'h0, be}, {28'h0, v.exp_be});
            chk({tag, "_writedata"}, wd, v.exp_wd);
        end
        if (!v.exp_err) begin
            chk({tag, "_mm_address"}, {22'h0, ma}, {22'h0, v.exp_ma});
        end
        @(posedge CLK); #1;
        mem_read = 1'b0; mem_write = 1'b0;
        @(negedge CLK);
        chk({tag, "_err_pulse_cleared"}, {31'h0, access_error}, 32'h0);
        chk({tag, "_idle_busywait"}, {31'h0, busywait}, 32'h0);
    endtask

    initial begin
        //          rd    wr    f3      addr          wd            mrd           wt bsy srd   swr   be       wd            ma      rd            err
        vecs[0]  = '{1'b1, 1'b0, 3'b010, 32'h0000_0010, 32'h0,        32'hDEAD_BEEF, 2, 5, 1'b1, 1'b0, 4'b0000, 32'h0,        10'h004, 32'hDEAD_BEEF, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 3'b000, 32'h0000_0013, 32'h0,        32'h8011_2233, 0, 3, 1'b1, 1'b0, 4'b0000, 32'h0,        10'h004, 32'hFFFF_FF80, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 3'b100, 32'h0000_0013, 32'h0,        32'h8011_2233, 0, 3, 1'b1, 1'b0, 4'b0000, 32'h0,        10'h004, 32'h0000_0080, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 3'b001, 32'h0000_0022, 32'h0000_ABCD, 32'h0,        0, 3, 1'b0, 1'b1, 4'b1100, 32'hABCD_ABCD, 10'h008, 32'h0000_0080, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 3'b010, 32'h0000_0006, 32'h0,        32'h1111_1111, 0, 1, 1'b0, 1'b0, 4'b0000, 32'h0,        10'h000, 32'h0000_0000, 1'b1};
        vecs[5]  = '{1'b0, 1'b1, 3'b000, 32'h0000_0007, 32'h0000_005A, 32'h0,        0, 3, 1'b0, 1'b1, 4'b1000, 32'h5A5A_5A5A, 10'h001, 32'h0000_0000, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 3'b001, 32'h0000_0002, 32'h0,        32'h8001_7FFF, 0, 3, 1'b1, 1'b0, 4'b0000, 32'h0,        10'h000, 32'hFFFF_8001, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 3'b101, 32'h0000_0002, 32'h0,        32'h8001_7FFF, 0, 3, 1'b1, 1'b0, 4'b0000, 32'h0,        10'h000, 32'h0000_8001, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 3'b001, 32'h0000_0000, 32'h0,        32'h8001_7FFF, 0, 3, 1'b1, 1'b0, 4'b0000, 32'h0,        10'h000, 32'h0000_7FFF, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 3'b000, 32'h0000_0001, 32'h0,        32'h1234_5678, 1, 4, 1'b1, 1'b0, 4'b0000, 32'h0,        10'h000, 32'h0000_0056, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 3'b010, 32'h0000_01FC, 32'hCAFE_F00D, 32'h0,        0, 3, 1'b0, 1'b1, 4'b1111, 32'hCAFE_F00D, 10'h07F, 32'h0000_0056, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 3'b101, 32'h0000_0003, 32'h0,        32'hFFFF_FFFF, 0, 1, 1'b0, 1'b0, 4'b0000, 32'h0,        10'h000, 32'h0000_0000, 1'b1};
        vecs[12] = '{1'b1, 1'b0, 3'b010, 32'h0000_1010, 32'h0,        32'h0BAD_F00D, 0, 3, 1'b1, 1'b0, 4'b0000, 32'h0,        10'h004, 32'h0BAD_F00D, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 3'b100, 32'h0000_0000, 32'h0000_0001, 32'h0,        0, 1, 1'b0, 1'b0, 4'b0000, 32'h0,        10'h000, 32'h0000_0000, 1'b1};
        vecs[14] = '{1'b1, 1'b1, 3'b000, 32'h0000_0004, 32'h0000_00A5, 32'h7777_7777, 0, 3, 1'b0, 1'b1, 4'b0001, 32'hA5A5_A5A5, 10'h001, 32'h0000_0000, 1'b0};
        vecs[15] = '{1'b0, 1'b1, 3'b001, 32'h0000_0021, 32'h0000_1234, 32'h0,        0, 1, 1'b0, 1'b0, 4'b0000, 32'h0,        10'h000, 32'h0000_0000, 1'b1};
        vecs[16] = '{1'b1, 1'b0, 3'b110, 32'h0000_0000, 32'h0,        32'h2222_2222, 0, 1, 1'b0, 1'b0, 4'b0000, 32'h0,        10'h000, 32'h0000_0000, 1'b1};
        vecs[17] = '{1'b1, 1'b0, 3'b010, 32'h0000_0008, 32'h0,        32'h1122_3344, 0, 3, 1'b1, 1'b0, 4'b0000, 32'h0,        10'h002, 32'h1122_3344, 1'b0};

        RESET = 1'b1; mem_read = 1'b1; mem_write = 1'b0; func3 = 3'b010;
        address = 32'h0; write_data = 32'h0; mm_readdata = 32'h0; mm_busywait = 1'b0;
        @(negedge CLK);
        chk("reset_busywait", {31'h0, busywait}, 32'h0);
        chk("reset_read_data", read_data, 32'h0);
        chk("reset_strobes", {30'h0, mm_read, mm_write}, 32'h0);
        chk("reset_mm_address", {22'h0, mm_address}, 32'h0);
        chk("reset_mm_lanes", mm_writedata | {28'h0, mm_byteenable}, 32'h0);
        chk("reset_access_error", {31'h0, access_error}, 32'h0);
        @(posedge CLK); #1;
        RESET = 1'b0; mem_read = 1'b0;

        for (int i = 0; i < 18; i++) begin
            run_vec(vecs[i], $sformatf("v%0d", i));
        end

        // Reset asserted mid-ACCESS clears everything without a clock edge.
        @(posedge CLK); #1;
        mem_read = 1'b1; mem_write = 1'b0; func3 = 3'b010; address = 32'h0000_0040;
        mm_readdata = 32'h5555_AAAA; wait_cfg = 5;
        repeat (3) @(negedge CLK);
        chk("midrst_pre_mm_read", {31'h0, mm_read}, 32'h1);
        chk("midrst_pre_busywait", {31'h0, busywait}, 32'h1);
        #2;
        RESET = 1'b1; mem_read = 1'b0;
        #1;
        chk("midrst_mm_read", {31'h0, mm_read}, 32'h0);
        chk("midrst_busywait", {31'h0, busywait}, 32'h0);
        chk("midrst_read_data", read_data, 32'h0);
        chk("midrst_mm_address", {22'h0, mm_address}, 32'h0);
        @(posedge CLK); #1;
        RESET = 1'b0;
        run_vec(vecs[2], "post_reset_lbu");
        run_vec(vecs[3], "post_reset_sh");

`ifdef DMEM_TIMEOUT_EN
        begin
            vec_t tv;
            tv = '{1'b1, 1'b0, 3'b010, 32'h0000_0020, 32'h0, 32'h9999_9999, 1000, 66,
                   1'b1, 1'b0, 4'b0000, 32'h0, 10'h008, 32'h0000_0000, 1'b1};
            run_vec(tv, "timeout_lw");
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/data_memory_controller.md
Name: data_memory_controller

Overview:
- Sits directly downstream of the memory access stage and consumes its mem_read/mem_write/func3/address/store-data requests.
- Converts each request into a word-aligned, byte-enabled transaction on an external multi-cycle data memory port.
- Formats load results with sign or zero extension, and raises busywait to stall the whole pipeline until the access completes.

Parameters:
- WORD_ADDR_BITS, 10: width of the word address driven to the backing memory (depth 1024 words).
- TIMEOUT_CYCLES, 64: watchdog limit, used only when DMEM_TIMEOUT_EN is defined.

Ports:
- CLK  input  1  system clock, rising edge
- RESET  input  1  asynchronous, active-high reset
- mem_read  input  1  load request from the memory access stage
- mem_write  input  1  store request from the memory access stage
- func3  input  3  load/store width code: 000 B, 001 H, 010 W, 100 BU, 101 HU
- address  input  32  byte address (ALU result)
- write_data  input  32  store data (rs2)
- read_data  output  32  formatted load result, registered
- busywait  output  1  pipeline stall request
- access_error  output  1  pulse: misaligned access, illegal func3, or timeout
- mm_read  output  1  backing memory read strobe
- mm_write  output  1  backing memory write strobe
- mm_address  output  WORD_ADDR_BITS  word address, address[WORD_ADDR_BITS+1:2]
- mm_writedata  output  32  lane-replicated store data
- mm_byteenable  output  4  byte lanes to write
- mm_readdata  input  32  backing memory read word
- mm_busywait  input  1  backing memory not ready

Behaviour:
- Reset (asynchronous, active-high) forces the following immediately, mid-transaction included:
  - state IDLE
  - read_data=0, busywait=0, access_error=0
  - mm_read=0, mm_write=0, mm_address=0, mm_writedata=0, mm_byteenable=0
- FSM states are IDLE, ACCESS and DONE.
- IDLE:
  - busywait = mem_read|mem_write, combinational, in the same cycle.
  - On the next edge with a request: latch address/func3/write_data and check legality.
  - Legal request: go to ACCESS.
  - Illegal request: go to DONE with access_error=1, read_data=0, and no memory strobes.
- Legality rules:
  - H/HU requires address[0]=0.
  - W requires address[1:0]=00.
  - func3 values 011, 110 and 111 are illegal.
  - Store with func3 100 or 101 is illegal.
- ACCESS:
  - Exactly one of mm_read/mm_write is high, registered. Outputs stay stable while mm_busywait=1.
  - busywait=1 throughout.
  - At the first edge with mm_busywait=0:
    - load: read_data is loaded with the formatted lane of mm_readdata.
    - Go to DONE and drop the strobes.
- DONE:
  - Lasts exactly 1 cycle with busywait=0, so the pipeline advances on this edge.
  - Next state is always IDLE. The new request is sampled on the following cycle, so there is no re-trigger of the completed request.
- access_error:
  - Valid only during DONE; 0 otherwise.
- Store lanes:
  - SB: byteenable = 0001<<address[1:0], writedata = {4{wd[7:0]}}.
  - SH: byteenable = 0011<<address[1:0], writedata = {2{wd[15:0]}}.
  - SW: byteenable = 1111, writedata = wd.
- Load lanes:
  - LB/LBU select byte address[1:0].
  - LH/LHU select half address[1].
  - LB/LH sign-extend; LBU/LHU zero-extend.
- mem_read and mem_write asserted together: treated as a store; the read is ignored.
- read_data holds its value across stores and idle cycles until the next completed load.
- Minimum latency for a legal access is mm wait cycles + 3 cycles of busywait: IDLE, ACCESS, and the final capture.

Optional Feature:
- DMEM_TIMEOUT_EN, defined:
  - A counter increments each ACCESS cycle with mm_busywait=1.
  - On reaching TIMEOUT_CYCLES the controller drops the strobes and enters DONE with access_error=1. A load then returns read_data=0.
  - The counter clears on entry to ACCESS and on reset.
- DMEM_TIMEOUT_EN, undefined: no counter exists, and ACCESS waits indefinitely on mm_busywait.

Decomposition:
- Shared package (memory_access_pkg):
  - func3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU
  - FSM state encoding
- Sub-module load_store_align: purely combinational.
  - Inputs: func3, address[1:0], write_data, mm_readdata.
  - Outputs: byteenable, lane-replicated write data, extended load data, misaligned/illegal flag.
- The FSM, latches and watchdog stay in data_memory_controller.

Test Plan:
- LW from 0x0000_0010 with mm_busywait high for 2 cycles and mm_readdata=0xDEADBEEF -> mm_read and mm_address=4 asserted; read_data=0xDEADBEEF; busywait high for 5 cycles, then low for 1.
- LB and LBU from 0x13 with mm_readdata=0x80112233 -> read_data=0xFFFFFF80 and 0x00000080 respectively.
- SH of 0x0000ABCD to 0x22 -> mm_write=1, mm_byteenable=1100, mm_writedata=0xABCDABCD; read_data unchanged.
- LW at 0x06 -> no mm strobe, access_error=1 in DONE, read_data=0; the next request (SB to 0x07, data 0x5A) gives byteenable=1000 and writedata=0x5A5A5A5A.
- RESET pulsed mid-ACCESS -> strobes, busywait and read_data go to 0 without waiting for a clock edge; the next request after release proceeds normally.
- DMEM_TIMEOUT_EN with mm_busywait held high -> after 64 ACCESS cycles, DONE with access_error=1 and busywait=0 for 1 cycle.
